uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

- Receive-side sequencer that consumes the 16x oversample tick from the baud clock generator.
- Sequences start-bit qualification, mid-bit majority sampling, optional parity and stop-bit check.
- Delivers each received byte on a valid/ready interface to the APB UART register block, with per-byte error flags and an overrun pulse.

## Interface

Parameters:
- DATA_BITS, 8: data bits per frame (5..9), LSB first.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 1 = odd parity, 0 = even (used only when PARITY_EN = 1).
- OVERSAMPLE, 16: rx_tick pulses per bit time (≥ 8, even).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_tick  in  1  one-clk pulse, OVERSAMPLE per bit time (baud generator rx_clk).
- rxd  in  1  asynchronous serial line, idle high.
- rx_data  out  DATA_BITS  received byte, valid while rx_valid = 1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts when rx_valid && rx_ready at a clk edge.
- frame_err  out  1  stop bit sampled 0 for the byte in rx_data.
- parity_err  out  1  parity mismatch for the byte in rx_data (0 if PARITY_EN = 0).
- overrun  out  1  one-clk pulse: completed byte dropped because rx_valid was still pending.
- busy  out  1  1 in any state other than IDLE.

## Operation

- rxd passes through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value rxs.
- All state advances only on clk edges where rx_tick = 1, except the output handshake, which runs every clk.
- Tick counter: 0..OVERSAMPLE-1. Bit value = majority of rxs at counts M-1, M, M+1, where M = OVERSAMPLE/2.
- Line arming: armed is set when rxs = 1 is seen on a tick in IDLE. A start is detected only while armed. This prevents a held-low line (break) from retriggering.
- FSM states and transitions:
  - IDLE: on tick with armed && rxs = 0 → START; counter = 0; armed cleared.
  - START: at count M+1, majority = 1 → IDLE (glitch, no output). At count OVERSAMPLE-1 → DATA with bit index 0.
  - DATA: majority shifted in at bit position index (LSB first). At count OVERSAMPLE-1: if index = DATA_BITS-1 → PARITY if PARITY_EN, else STOP; otherwise index+1.
  - PARITY: majority compared with the XOR of the data bits (inverted if PARITY_ODD). At count OVERSAMPLE-1 → STOP.
  - STOP: at count M+1, evaluate the stop bit, commit the byte and flags to the outputs, → IDLE. This early return leaves half a bit of margin to catch the next start.
- Commit rules:
  - If rx_valid = 0, or a handshake occurs in the same clk: load rx_data, frame_err and parity_err, and set rx_valid = 1.
  - Otherwise: drop the new byte, keep the old outputs, pulse overrun.
- A framing-error byte is still delivered, with frame_err = 1.
- rx_valid && rx_ready clears rx_valid the next clk, unless a commit occurs in that same clk.

## Timing

- Reset values: rx_data = 0, rx_valid = 0, frame_err = 0, parity_err = 0, overrun = 0, busy = 0, state = IDLE, armed = 0, synchronizer = 1.
- All outputs are registered.
- rxd → rxs latency: 2 clk.
- rx_valid rises 1 clk after the rx_tick edge carrying STOP count M+1.
- busy rises 1 clk after the start-detect tick and falls together with the commit.
- Reset asserted mid-frame aborts immediately; the partial byte is discarded and no overrun is signalled.
- rx_tick absent (baud generator held in reset): the FSM freezes in place; the handshake still operates.

## Structure

- Package uart_pkg holds:
  - the rx_state_t enum {IDLE, START, DATA, PARITY, STOP};
  - localparam helpers for M and the counter width $clog2(OVERSAMPLE).
- One sub-module: sync_2ff (2-flop synchronizer with parameterized reset value), shared with the GPIO input path.

## Test plan

Bench setup: rx_tick every 104 clk (16 MHz, 9600 baud, 16x); 8N1 unless noted.

1. Send 0xA5, rx_ready = 1 → one rx_valid pulse with rx_data = 0xA5; frame_err = parity_err = overrun = 0.
2. rxd low for 3 ticks, then high → busy pulses, no rx_valid, FSM back in IDLE.
3. Send 0x3C with stop bit = 0, then hold rxd low for 2 frame times → rx_data = 0x3C with frame_err = 1; no further rx_valid until rxd returns high and a new frame 0x81 is received correctly.
4. rx_ready = 0; send 0x11 then 0x22 back-to-back → rx_data stays 0x11, overrun pulses exactly once. Then raise rx_ready → handshake, rx_valid = 0.
5. PARITY_EN = 1, PARITY_ODD = 0; send 0x07 with parity bit 0 → parity_err = 1. Send 0x07 with parity bit 1 → parity_err = 0.
6. Assert rst_n = 0 during data bit 4 of a frame → all outputs at reset values. Release and send 0x5A → rx_data = 0x5A, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART receive path.
//               - rx_state_t : receive sequencer states
//               - mid_count  : mid-bit tick count M for a given oversample
//               - cnt_width  : tick counter width for a given oversample
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int C_OVERSAMPLE_DFLT = 16;
    localparam int C_MID_DFLT        = C_OVERSAMPLE_DFLT / 2;
    localparam int C_CNT_W_DFLT      = $clog2(C_OVERSAMPLE_DFLT);

    // Centre of the bit cell, in oversample ticks.
    function automatic int mid_count(input int oversample);
        return oversample / 2;
    endfunction

    // Width of a counter spanning 0..oversample-1.
    function automatic int cnt_width(input int oversample);
        return $clog2(oversample);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous input.
//               RESET_VAL selects the value both flops take in reset so that
//               an idle-high line does not look like activity after reset.
// Ports       : clk   - destination clock
//               rst_n - asynchronous active-low reset
//               d     - asynchronous input
//               q     - synchronized output (2 clk latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART receive sequencer driven by an oversample tick. Qualifies
//               the start bit, majority-samples each bit at mid-cell, checks
//               optional parity and the stop bit, and hands each byte to the
//               register block over a valid/ready interface.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               rx_tick             - OVERSAMPLE pulses per bit time
//               rxd                 - serial line, idle high
//               rx_data/rx_valid    - received byte, held until accepted
//               rx_ready            - consumer accept
//               frame_err           - stop bit was 0 for the byte in rx_data
//               parity_err          - parity mismatch for the byte in rx_data
//               overrun             - 1-clk pulse, completed byte dropped
//               busy                - sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_mid   = mid_count(OVERSAMPLE);
    localparam int c_cnt_w = cnt_width(OVERSAMPLE);
    localparam int c_idx_w = $clog2(DATA_BITS);

    localparam logic [c_cnt_w-1:0] c_cnt_mid_m1 = c_cnt_w'(c_mid - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_mid    = c_cnt_w'(c_mid);
    localparam logic [c_cnt_w-1:0] c_cnt_mid_p1 = c_cnt_w'(c_mid + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(OVERSAMPLE - 1);
    localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(DATA_BITS - 1);
    localparam logic               c_par_en     = (PARITY_EN != 0);
    localparam logic               c_par_odd    = (PARITY_ODD != 0);

    logic                 w_rxs;
    rx_state_t            r_state,  w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt,    w_cnt_nxt;
    logic [c_idx_w-1:0]   r_idx,    w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift,  w_shift_nxt;
    logic                 r_smp0,   w_smp0_nxt;
    logic                 r_smp1,   w_smp1_nxt;
    logic                 r_armed,  w_armed_nxt;
    logic                 r_par_err, w_par_err_nxt;
    logic                 w_commit;
    logic                 w_maj;
    logic                 w_handshake;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (w_rxs)
    );

    // Third sample is taken live at count M+1, the first two are stored.
    assign w_maj       = (r_smp0 & r_smp1) | (r_smp0 & w_rxs) | (r_smp1 & w_rxs);
    assign w_handshake = rx_valid & rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_smp0    <= 1'b0;
            r_smp1    <= 1'b0;
            r_armed   <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_smp0    <= w_smp0_nxt;
            r_smp1    <= w_smp1_nxt;
            r_armed   <= w_armed_nxt;
            r_par_err <= w_par_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_shift_nxt   = r_shift;
        w_smp0_nxt    = r_smp0;
        w_smp1_nxt    = r_smp1;
        w_armed_nxt   = r_armed;
        w_par_err_nxt = r_par_err;
        w_commit      = 1'b0;

        if (rx_tick) begin
            if (r_state != IDLE) begin
                w_cnt_nxt = (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
                if (r_cnt == c_cnt_mid_m1) w_smp0_nxt = w_rxs;
                if (r_cnt == c_cnt_mid)    w_smp1_nxt = w_rxs;
            end

            case (r_state)
                IDLE: begin
                    // Arming requires a high line first, so a held break
                    // cannot retrigger reception.
                    if (w_rxs) begin
                        w_armed_nxt = 1'b1;
                    end else if (r_armed) begin
                        w_state_nxt = START;
                        w_cnt_nxt   = '0;
                        w_armed_nxt = 1'b0;
                    end
                end
                START: begin
                    if (r_cnt == c_cnt_mid_p1 && w_maj) begin
                        w_state_nxt = IDLE;
                    end else if (r_cnt == c_cnt_last) begin
                        w_state_nxt = DATA;
                        w_idx_nxt   = '0;
                    end
                end
                DATA: begin
                    if (r_cnt == c_cnt_mid_p1) w_shift_nxt[r_idx] = w_maj;
                    if (r_cnt == c_cnt_last) begin
                        if (r_idx == c_idx_last) begin
                            w_state_nxt = c_par_en ? PARITY : STOP;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (r_cnt == c_cnt_mid_p1) begin
                        w_par_err_nxt = w_maj ^ (^r_shift) ^ c_par_odd;
                    end
                    if (r_cnt == c_cnt_last) w_state_nxt = STOP;
                end
                STOP: begin
                    // Returning at mid-stop leaves half a bit to catch the
                    // next start edge.
                    if (r_cnt == c_cnt_mid_p1) begin
                        w_commit    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            busy    <= (w_state_nxt != IDLE);
            if (w_commit) begin
                if (!rx_valid || w_handshake) begin
                    rx_data    <= r_shift;
                    frame_err  <= ~w_maj;
                    parity_err <= c_par_en & r_par_err;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (w_handshake) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Self-checking bench for uart_rx_ctrl. An 8N1 instance runs a
//               table of frames plus directed corner sequences; an 8E1
//               instance covers parity.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int TDIV     = 4;
    localparam int BIT_CLKS = 16 * TDIV;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_tick = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun, busy;

    logic       rxd_p = 1'b1;
    logic       rx_ready_p = 1'b0;
    logic [7:0] rx_data_p;
    logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p, busy_p;

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] hs_data = '0;
    logic hs_fe = 1'b0;
    logic hs_pe = 1'b0;
    logic busy_seen = 1'b0;
    logic prev_valid = 1'b0;
    int div = 0;

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx_tick(rx_tick), .rxd(rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
    );

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .OVERSAMPLE(16)) dut_p (
        .clk(clk), .rst_n(rst_n), .rx_tick(rx_tick), .rxd(rxd_p),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
        .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p), .busy(busy_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (div == TDIV - 1) begin
            div     <= 0;
            rx_tick <= 1'b1;
        end else begin
            div     <= div + 1;
            rx_tick <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Handshake / overrun observer for the 8N1 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) begin
                hs_cnt++;
                hs_data = rx_data;
                hs_fe   = frame_err;
                hs_pe   = parity_err;
            end
            if (overrun) ov_cnt++;
            if (busy) busy_seen = 1'b1;
            if (rx_valid && !prev_valid) check("busy_low_at_commit", 32'(busy), 0);
        end
        prev_valid = rx_valid;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line_bit(input int which, input logic v);
        if (which == 0) rxd = v; else rxd_p = v;
        step(BIT_CLKS);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input logic par_en,
                              input logic par_bit, input logic stop);
        line_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) line_bit(which, d[i]);
        if (par_en) line_bit(which, par_bit);
        line_bit(which, stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int h0;
        int o0;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
        vecs[4] = '{8'h81, 1'b1, 8'h81, 1'b0};
        vecs[5] = '{8'h5A, 1'b1, 8'h5A, 1'b0};

        #2 rst_n = 1'b0;
        step(5);
        check("rst_rx_data",    32'(rx_data), 0);
        check("rst_rx_valid",   32'(rx_valid), 0);
        check("rst_frame_err",  32'(frame_err), 0);
        check("rst_parity_err", 32'(parity_err), 0);
        check("rst_overrun",    32'(overrun), 0);
        check("rst_busy",       32'(busy), 0);
        rst_n = 1'b1;
        step(2 * BIT_CLKS);

        // Table of 8N1 frames, consumer always ready.
        for (int v = 0; v < 6; v++) begin
            h0 = hs_cnt;
            o0 = ov_cnt;
            send_frame(0, vecs[v].data, 1'b0, 1'b0, vecs[v].stop);
            line_bit(0, 1'b1);
            check($sformatf("vec%0d_count", v), 32'(hs_cnt - h0), 1);
            check($sformatf("vec%0d_data", v),  32'(hs_data), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_fe", v),    32'(hs_fe), 32'(vecs[v].exp_fe));
            check($sformatf("vec%0d_pe", v),    32'(hs_pe), 0);
            check($sformatf("vec%0d_ov", v),    32'(ov_cnt - o0), 0);
            check($sformatf("vec%0d_valid", v), 32'(rx_valid), 0);
        end

        // Start-bit glitch: 3 ticks low.
        busy_seen = 1'b0;
        h0 = hs_cnt;
        rxd = 1'b0;
        step(3 * TDIV);
        rxd = 1'b1;
        step(2 * BIT_CLKS);
        check("glitch_busy_seen", 32'(busy_seen), 1);
        check("glitch_no_byte",   32'(hs_cnt - h0), 0);
        check("glitch_idle",      32'(busy), 0);

        // Framing error followed by a held break, then recovery.
        h0 = hs_cnt;
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        check("brk_count", 32'(hs_cnt - h0), 1);
        check("brk_data",  32'(hs_data), 32'h3C);
        check("brk_fe",    32'(hs_fe), 1);
        h0 = hs_cnt;
        step(20 * BIT_CLKS);
        check("brk_no_retrigger", 32'(hs_cnt - h0), 0);
        check("brk_not_busy",     32'(busy), 0);
        line_bit(0, 1'b1);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        line_bit(0, 1'b1);
        check("rec_count", 32'(hs_cnt - h0), 1);
        check("rec_data",  32'(hs_data), 32'h81);
        check("rec_fe",    32'(hs_fe), 0);

        // Overrun: consumer stalled across two back-to-back frames.
        rx_ready = 1'b0;
        h0 = hs_cnt;
        o0 = ov_cnt;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        line_bit(0, 1'b1);
        check("ovr_valid", 32'(rx_valid), 1);
        check("ovr_data",  32'(rx_data), 32'h11);
        check("ovr_pulse", 32'(ov_cnt - o0), 1);
        check("ovr_no_hs", 32'(hs_cnt - h0), 0);
        rx_ready = 1'b1;
        step(3);
        check("ovr_hs_count", 32'(hs_cnt - h0), 1);
        check("ovr_hs_data",  32'(hs_data), 32'h11);
        check("ovr_cleared",  32'(rx_valid), 0);

        // Even parity on the second instance: 0x07 has odd weight, so the
        // correct parity bit is 1.
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        line_bit(1, 1'b1);
        check("par_bad_valid", 32'(rx_valid_p), 1);
        check("par_bad_data",  32'(rx_data_p), 32'h07);
        check("par_bad_pe",    32'(parity_err_p), 1);
        check("par_bad_fe",    32'(frame_err_p), 0);
        rx_ready_p = 1'b1;
        step(1);
        rx_ready_p = 1'b0;
        step(1);
        check("par_bad_taken", 32'(rx_valid_p), 0);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        line_bit(1, 1'b1);
        check("par_ok_valid", 32'(rx_valid_p), 1);
        check("par_ok_pe",    32'(parity_err_p), 0);
        check("par_ok_ovr",   32'(overrun_p), 0);
        rx_ready_p = 1'b1;
        step(1);
        rx_ready_p = 1'b0;

        // Reset in the middle of data bit 4.
        o0 = ov_cnt;
        line_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) line_bit(0, 1'b1);
        rxd = 1'b0;
        step(BIT_CLKS / 2);
        check("mid_busy_before_rst", 32'(busy), 1);
        rst_n = 1'b0;
        step(1);
        check("mid_rst_data",    32'(rx_data), 0);
        check("mid_rst_valid",   32'(rx_valid), 0);
        check("mid_rst_fe",      32'(frame_err), 0);
        check("mid_rst_pe",      32'(parity_err), 0);
        check("mid_rst_ovr",     32'(overrun), 0);
        check("mid_rst_busy",    32'(busy), 0);
        check("mid_rst_data_p",  32'(rx_data_p), 0);
        rxd = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(BIT_CLKS);
        h0 = hs_cnt;
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        line_bit(0, 1'b1);
        check("post_rst_count", 32'(hs_cnt - h0), 1);
        check("post_rst_data",  32'(hs_data), 32'h5A);
        check("post_rst_fe",    32'(hs_fe), 0);
        check("post_rst_pe",    32'(hs_pe), 0);
        check("post_rst_ov",    32'(ov_cnt - o0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
